// File: rtl/cqu_mips_pkg.sv
// cqu_mips_pkg: shared constants and the response payload type for the fetch-side instruction memory.
package cqu_mips_pkg;

    localparam logic [31:0] IMEM_BASE  = 32'h0040_0000;
    localparam int          IMEM_WORDS = 1024;
    localparam int          WORD_W     = 32;
    localparam logic [31:0] RESET_PC   = IMEM_BASE;

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
        logic              err;
    } resp_t;

    // A fetch is bad when it is not word aligned or falls outside the 4 KB window at IMEM_BASE.
    function automatic logic imem_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:12] != IMEM_BASE[31:12]);
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// resp_fifo: synchronous FIFO holding completed fetch responses.
//   clk, rst_n (async, active low), clr (synchronous drop-all), wr_en/wr_data push,
//   rd_en pop, rd_data head entry, empty/full status.
module resp_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 65
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_wr, do_rd;

    // Pointers wrap explicitly so non power-of-two depths work.
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign rd_data = mem_q[rp_q];
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);

    always_comb begin
        mem_d = mem_q;
        wp_d  = clr ? '0 : (do_wr ? inc(wp_q) : wp_q);
        rp_d  = clr ? '0 : (do_rd ? inc(rp_q) : rp_q);
        cnt_d = clr ? '0 : cnt_q + CW'(do_wr) - CW'(do_rd);
        if (do_wr && !clr) mem_d[wp_q] = wr_data;
    end

    // Storage is reset too, so the head reads as zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full && !rd_en && !clr));

endmodule

// File: rtl/inst_mem_resp.sv
// inst_mem_resp: fixed-latency instruction memory responder with credit flow control and flush.
//   clk, rst (async, active low); req_valid/req_ready/req_addr fetch request;
//   resp_valid/resp_ready/resp_data/resp_addr/resp_err in-order response;
//   flush drops all outstanding work; ld_en/ld_idx/ld_data preload write port.
module inst_mem_resp import cqu_mips_pkg::*; #(
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 2,
    parameter int WORDS       = IMEM_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_data,
    output logic [31:0]       resp_addr,
    output logic              resp_err,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [9:0]        ld_idx,
    input  logic [WORD_W-1:0] ld_data
);

    // The FIFO write edge is the last latency stage, so only LATENCY-1 registers precede it.
    localparam int PD = (LATENCY > 1) ? LATENCY - 1 : 1;

    logic [WORD_W-1:0] mem [WORDS];
    logic [2:0]        cnt_q, cnt_d;
    logic              acc, cons, bad, f_wr, f_empty, f_full;
    resp_t             in_pl, f_wr_pl, f_rd_pl;

    assign bad        = imem_bad(req_addr);
    assign in_pl      = '{addr: req_addr, data: bad ? '0 : mem[req_addr[11:2]], err: bad};
    assign req_ready  = rst && !flush && (cnt_q < 3'(OUTSTANDING));
    assign acc        = req_valid && req_ready;
    assign resp_valid = !f_empty && !flush;
    assign cons       = resp_valid && resp_ready;
    assign resp_data  = f_rd_pl.data;
    assign resp_addr  = f_rd_pl.addr;
    assign resp_err   = f_rd_pl.err;

    // Read happens combinationally in the accept cycle, so a same-edge preload returns old data.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_data;
    end

    // cnt is the credit count: it bounds FIFO occupancy, so the FIFO never needs to push back.
    always_comb begin
        cnt_d = flush ? '0 : cnt_q + {2'b0, acc} - {2'b0, cons};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    if (LATENCY == 1) begin : g_direct
        assign f_wr    = acc;
        assign f_wr_pl = in_pl;
    end else begin : g_pipe
        logic [PD-1:0] v_q, v_d;
        resp_t         pl_q [PD];
        resp_t         pl_d [PD];
        always_comb begin
            v_d      = '0;
            pl_d     = pl_q;
            v_d[0]   = acc && !flush;
            pl_d[0]  = in_pl;
            for (int i = 1; i < PD; i++) begin
                v_d[i]  = v_q[i-1] && !flush;
                pl_d[i] = pl_q[i-1];
            end
        end
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q <= '0;
                for (int i = 0; i < PD; i++) pl_q[i] <= '0;
            end else begin
                v_q  <= v_d;
                pl_q <= pl_d;
            end
        end
        assign f_wr    = v_q[PD-1];
        assign f_wr_pl = pl_q[PD-1];
    end

    resp_fifo #(
        .DEPTH (OUTSTANDING),
        .W     ($bits(resp_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .clr     (flush),
        .wr_en   (f_wr),
        .wr_data (f_wr_pl),
        .rd_en   (cons),
        .rd_data (f_rd_pl),
        .empty   (f_empty),
        .full    (f_full)
    );

    logic unused_full;
    assign unused_full = f_full;

endmodule

// File: tb/tb_inst_mem_resp.sv
// tb_inst_mem_resp: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_inst_mem_resp;

    localparam int LAT = 2;
    localparam int OUT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid = 1'b0, resp_ready = 1'b0, flush = 1'b0, ld_en = 1'b0;
    logic [31:0] req_addr = '0, ld_data = '0;
    logic [9:0]  ld_idx = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_data, resp_addr;

    int checks = 0, errors = 0, cyc = 0, k;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          t;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mm  [1024];
    logic [31:0] pre [16];
    logic [31:0] ga[$], gd[$];
    logic        ge[$];

    inst_mem_resp #(.LATENCY(LAT), .OUTSTANDING(OUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_addr  (resp_addr),
        .resp_err   (resp_err),
        .flush      (flush),
        .ld_en      (ld_en),
        .ld_idx     (ld_idx),
        .ld_data    (ld_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    // Model: outstanding requests in order, each stamped with its accept cycle.
    always @(negedge clk) begin
        logic exp_rdy, exp_rv, acc, cons, bad;
        cyc++;
        if (!rst) begin
            q.delete();
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_data", resp_data, 0);
            chk("rst_resp_addr", resp_addr, 0);
            chk("rst_resp_err", resp_err, 0);
        end else begin
            exp_rdy = (q.size() < OUT) && !flush;
            exp_rv  = (q.size() > 0) && !flush && (cyc >= q[0].t + LAT);
            chk("req_ready", req_ready, exp_rdy);
            chk("resp_valid", resp_valid, exp_rv);
            if (exp_rv) begin
                chk("resp_data", resp_data, q[0].data);
                chk("resp_addr", resp_addr, q[0].addr);
                chk("resp_err", resp_err, q[0].err);
            end
            acc  = req_valid && exp_rdy;
            cons = exp_rv && resp_ready;
            bad  = (req_addr[1:0] != 2'b00) || (req_addr[31:12] != 20'h00400);
            if (flush) q.delete();
            else begin
                if (cons) void'(q.pop_front());
                if (acc) q.push_back('{addr: req_addr, data: bad ? 32'h0 : mm[req_addr[11:2]], err: bad, t: cyc});
            end
        end
        if (ld_en) mm[ld_idx] = ld_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rv(output int n);
        n = 0;
        #1;
        while (resp_valid !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk("wait_rv_timeout", 32'(n < 20), 1);
    endtask

    task automatic collect(input int n);
        logic dropv;
        ga.delete(); gd.delete(); ge.delete();
        for (int i = 0; i < 30 && ga.size() < n; i++) begin
            #1;
            if (resp_valid && resp_ready) begin
                ga.push_back(resp_addr);
                gd.push_back(resp_data);
                ge.push_back(resp_err);
            end
            dropv = req_valid && req_ready;
            tick();
            if (dropv) req_valid = 1'b0;
        end
        chk("collect_count", 32'(ga.size()), 32'(n));
    endtask

    initial begin
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1 chk("ready_after_rst", req_ready, 1);
        for (int i = 0; i < 16; i++) begin
            tick();
            ld_en   = 1'b1;
            ld_idx  = 10'(i);
            ld_data = (i == 0) ? 32'h2408_0001 : $urandom;
            pre[i]  = ld_data;
        end
        tick();
        ld_en = 1'b0;

        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 32'h0040_0000;
        tick();
        req_valid = 1'b0;
        wait_rv(k);
        chk("first_latency", 32'(k), 1);
        chk("first_data", resp_data, 32'h2408_0001);
        chk("first_addr", resp_addr, 32'h0040_0000);
        chk("first_err", resp_err, 0);
        tick();

        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h0040_0000;
        tick();
        req_addr = 32'h0040_0004;
        tick();
        req_addr = 32'h0040_0008;
        repeat (3) begin
            #1 chk("held_ready", req_ready, 0);
            tick();
        end
        resp_ready = 1'b1;
        collect(3);
        chk("order_0", ga[0], 32'h0040_0000);
        chk("order_1", ga[1], 32'h0040_0004);
        chk("order_2", ga[2], 32'h0040_0008);
        chk("order_data_1", gd[1], pre[1]);

        req_valid = 1'b1;
        req_addr  = 32'h0040_0002;
        tick();
        req_addr = 32'h0050_0000;
        tick();
        req_valid = 1'b0;
        collect(2);
        chk("misaligned_err", 32'(ge[0]), 1);
        chk("misaligned_data", gd[0], 0);
        chk("range_err", 32'(ge[1]), 1);
        chk("range_data", gd[1], 0);
        chk("range_addr", ga[1], 32'h0050_0000);

        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h0040_0000;
        tick();
        req_addr = 32'h0040_0004;
        tick();
        req_valid = 1'b0;
        flush     = 1'b1;
        #1 chk("flush_ready", req_ready, 0);
        chk("flush_masks_valid", resp_valid, 0);
        tick();
        flush      = 1'b0;
        resp_ready = 1'b1;
        repeat (3) begin
            #1 chk("post_flush_ready", req_ready, 1);
            chk("post_flush_no_resp", resp_valid, 0);
            tick();
        end
        req_valid = 1'b1;
        req_addr  = 32'h0040_0008;
        tick();
        req_valid = 1'b0;
        wait_rv(k);
        chk("post_flush_latency", 32'(k), 1);
        chk("post_flush_data", resp_data, pre[2]);
        chk("post_flush_addr", resp_addr, 32'h0040_0008);
        tick();

        req_valid = 1'b1;
        req_addr  = 32'h0040_000C;
        ld_en     = 1'b1;
        ld_idx    = 10'd3;
        ld_data   = 32'hCAFE_0003;
        tick();
        req_valid = 1'b0;
        ld_en     = 1'b0;
        wait_rv(k);
        chk("same_cycle_old_word", resp_data, pre[3]);
        tick();
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        wait_rv(k);
        chk("repeat_new_word", resp_data, 32'hCAFE_0003);
        tick();

        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h0040_0000;
        tick();
        req_addr = 32'h0040_0004;
        tick();
        req_valid = 1'b0;
        tick();
        #1 chk("pre_rst_valid", resp_valid, 1);
        rst = 1'b0;
        #1 chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_valid", resp_valid, 0);
        chk("mid_rst_data", resp_data, 0);
        chk("mid_rst_addr", resp_addr, 0);
        chk("mid_rst_err", resp_err, 0);
        tick();
        rst = 1'b1;
        #1 chk("release_ready", req_ready, 1);
        chk("release_valid", resp_valid, 0);

        repeat (3000) begin
            int idx, r;
            tick();
            idx        = $urandom_range(0, 15);
            r          = $urandom_range(0, 9);
            req_valid  = ($urandom_range(0, 2) != 0);
            req_addr   = (r == 0) ? (32'h0040_0000 | (32'(idx) << 2) | 32'($urandom_range(1, 3))) :
                         (r == 1) ? (32'h0080_0000 | (32'(idx) << 2)) :
                                    (32'h0040_0000 | (32'(idx) << 2));
            resp_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            ld_en      = ($urandom_range(0, 7) == 0);
            ld_idx     = 10'($urandom_range(0, 15));
            ld_data    = $urandom;
            rst        = ($urandom_range(0, 399) != 0);
        end
        tick();
        rst = 1'b1;
        req_valid = 1'b0;
        flush = 1'b0;
        ld_en = 1'b0;
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
